// File: rtl/mant_seg_adder.sv
// mant_seg_adder: multi-cycle segmented mantissa adder behind the FP add
// controller's Adder_* four-phase valid/ack handshake. The carry chain is
// broken into SEG_W-bit segments, one segment added per clock.
//
// Optional feature macro: ADDER_ZERO_DETECT_EN
//   defined   -> Adder_Exc[0] flags a zero result ({carry, sum} == 0)
//   undefined -> zero detect removed, Adder_Exc is constant 2'b00
//
// Ports:
//   CLK             clock, all state on rising edge
//   RST             asynchronous active-high reset
//   Adder_valid     request, held by caller until Adder_ack is seen
//   Adder_datain1   operand A, sampled at request capture only
//   Adder_datain2   operand B, sampled at request capture only
//   Adder_ack       result valid, held until Adder_valid falls
//   Adder_dataout   sum[DATA_W-1:0]
//   Adder_carryout  carry out of the MSB
//   Adder_Exc       exception code: 00 none, 01 zero result, bit1 reserved
//   Busy            high in any state other than IDLE
//   Abort           one-cycle pulse when a request is withdrawn mid-add
module mant_seg_adder #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SEG_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Adder_valid,
  input  logic [DATA_W-1:0] Adder_datain1,
  input  logic [DATA_W-1:0] Adder_datain2,
  output logic              Adder_ack,
  output logic [DATA_W-1:0] Adder_dataout,
  output logic              Adder_carryout,
  output logic [1:0]        Adder_Exc,
  output logic              Busy,
  output logic              Abort
);

  localparam int unsigned NSEG  = DATA_W / SEG_W;
  localparam int unsigned CNT_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  // Segment width must tile the operand exactly.
  if ((DATA_W % SEG_W) != 0) begin : g_bad_seg_w
    $error("mant_seg_adder: SEG_W must divide DATA_W exactly");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0]  seg_q, seg_d;
  logic              carry_q, carry_d;
  logic              ack_d;
  logic [DATA_W-1:0] dataout_d;
  logic              carryout_d;
  logic [1:0]        exc_d;
  logic              abort_d;

  int unsigned       seg_lsb;
  logic [SEG_W-1:0]  a_seg, b_seg;
  logic [SEG_W:0]    seg_res;

  // One segment of the carry chain: {c, s} = A[seg] + B[seg] + carry.
  always_comb begin
    seg_lsb = 32'(seg_q) * SEG_W;
    a_seg   = op_a_q[seg_lsb +: SEG_W];
    b_seg   = op_b_q[seg_lsb +: SEG_W];
    seg_res = {1'b0, a_seg} + {1'b0, b_seg} + (SEG_W+1)'(carry_q);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    sum_d      = sum_q;
    seg_d      = seg_q;
    carry_d    = carry_q;
    ack_d      = Adder_ack;
    dataout_d  = Adder_dataout;
    carryout_d = Adder_carryout;
    exc_d      = Adder_Exc;
    abort_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Adder_valid) begin
          op_a_d  = Adder_datain1;
          op_b_d  = Adder_datain2;
          seg_d   = '0;
          carry_d = 1'b0;
          state_d = ADD;
        end
      end

      ADD: begin
        if (!Adder_valid) begin
          // Caller withdrew: drop the partial sum, leave results untouched.
          abort_d = 1'b1;
          state_d = IDLE;
        end else begin
          sum_d[seg_lsb +: SEG_W] = seg_res[SEG_W-1:0];
          carry_d                 = seg_res[SEG_W];
          if (seg_q == CNT_W'(NSEG - 1)) begin
            dataout_d  = sum_d;
            carryout_d = seg_res[SEG_W];
`ifdef ADDER_ZERO_DETECT_EN
            exc_d      = {1'b0, ~|{seg_res[SEG_W], sum_d}};
`else
            exc_d      = 2'b00;
`endif
            ack_d      = 1'b1;
            state_d    = DONE;
          end else begin
            seg_d = seg_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        if (!Adder_valid) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        ack_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q        <= IDLE;
      op_a_q         <= '0;
      op_b_q         <= '0;
      sum_q          <= '0;
      seg_q          <= '0;
      carry_q        <= 1'b0;
      Adder_ack      <= 1'b0;
      Adder_dataout  <= '0;
      Adder_carryout <= 1'b0;
      Adder_Exc      <= 2'b00;
      Busy           <= 1'b0;
      Abort          <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      sum_q          <= sum_d;
      seg_q          <= seg_d;
      carry_q        <= carry_d;
      Adder_ack      <= ack_d;
      Adder_dataout  <= dataout_d;
      Adder_carryout <= carryout_d;
      Adder_Exc      <= exc_d;
      Busy           <= (state_d != IDLE);
      Abort          <= abort_d;
    end
  end

endmodule

// File: tb/tb_mant_seg_adder.sv
// Directed self-checking bench for mant_seg_adder at default parameters.
module tb_mant_seg_adder;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned NSEG   = 4;

  logic              CLK;
  logic              RST;
  logic              Adder_valid;
  logic [DATA_W-1:0] Adder_datain1;
  logic [DATA_W-1:0] Adder_datain2;
  logic              Adder_ack;
  logic [DATA_W-1:0] Adder_dataout;
  logic              Adder_carryout;
  logic [1:0]        Adder_Exc;
  logic              Busy;
  logic              Abort;

  int n_vec;
  int n_err;

  mant_seg_adder dut (
    .CLK            (CLK),
    .RST            (RST),
    .Adder_valid    (Adder_valid),
    .Adder_datain1  (Adder_datain1),
    .Adder_datain2  (Adder_datain2),
    .Adder_ack      (Adder_ack),
    .Adder_dataout  (Adder_dataout),
    .Adder_carryout (Adder_carryout),
    .Adder_Exc      (Adder_Exc),
    .Busy           (Busy),
    .Abort          (Abort)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a request, wait (bounded) for ack, check result, hold, release.
  task automatic run_req(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] exp_sum, input logic exp_c, input logic [1:0] exp_exc);
    int cyc;
    logic [23:0] held;
    @(negedge CLK);
    Adder_valid   = 1'b1;
    Adder_datain1 = a;
    Adder_datain2 = b;
    @(posedge CLK);              // capture edge
    @(negedge CLK);
    Adder_datain1 = ~a;          // operand changes after capture are ignored
    Adder_datain2 = 24'h5A5A5A;
    chk({tag, " busy"}, 32'(Busy), 32'd1);
    cyc = 0;
    while (!Adder_ack && cyc < 20) begin
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
    end
    chk({tag, " latency"}, 32'(cyc), 32'(NSEG));
    chk({tag, " sum"}, 32'(Adder_dataout), 32'(exp_sum));
    chk({tag, " carry"}, 32'(Adder_carryout), 32'(exp_c));
    chk({tag, " exc"}, 32'(Adder_Exc), 32'(exp_exc));
    held = Adder_dataout;
    repeat (2) @(negedge CLK);
    chk({tag, " hold ack"}, 32'(Adder_ack), 32'd1);
    chk({tag, " hold sum"}, 32'(Adder_dataout), 32'(held));
    Adder_valid = 1'b0;
    @(negedge CLK);
    chk({tag, " release ack"}, 32'(Adder_ack), 32'd0);
    chk({tag, " release busy"}, 32'(Busy), 32'd0);
    chk({tag, " kept sum"}, 32'(Adder_dataout), 32'(exp_sum));
  endtask

  initial begin
    logic [1:0] zexc;
    n_vec = 0;
    n_err = 0;
    RST = 1'b1;
    Adder_valid = 1'b0;
    Adder_datain1 = '0;
    Adder_datain2 = '0;
`ifdef ADDER_ZERO_DETECT_EN
    zexc = 2'b01;
`else
    zexc = 2'b00;
`endif

    repeat (2) @(negedge CLK);
    chk("reset ack", 32'(Adder_ack), 32'd0);
    chk("reset sum", 32'(Adder_dataout), 32'd0);
    chk("reset carry", 32'(Adder_carryout), 32'd0);
    chk("reset exc", 32'(Adder_Exc), 32'd0);
    chk("reset busy", 32'(Busy), 32'd0);
    chk("reset abort", 32'(Abort), 32'd0);
    RST = 1'b0;

    run_req("basic",  24'h400000, 24'h400000, 24'h800000, 1'b0, 2'b00);
    run_req("xseg",   24'h000FFF, 24'h000001, 24'h001000, 1'b0, 2'b00);
    run_req("cancel", 24'h123456, 24'hEDCBAA, 24'h000000, 1'b1, 2'b00);
    run_req("zero",   24'h000000, 24'h000000, 24'h000000, 1'b0, zexc);
    run_req("mixed",  24'hA5A5A5, 24'h3C3C3C, 24'hE1E1E1, 1'b0, 2'b00);

    // Withdrawal after two ADD edges.
    @(negedge CLK);
    Adder_valid   = 1'b1;
    Adder_datain1 = 24'h111111;
    Adder_datain2 = 24'h222222;
    repeat (3) @(posedge CLK);   // capture + 2 ADD edges
    @(negedge CLK);
    chk("abort pre", 32'(Abort), 32'd0);
    Adder_valid = 1'b0;
    @(negedge CLK);
    chk("abort pulse", 32'(Abort), 32'd1);
    chk("abort ack", 32'(Adder_ack), 32'd0);
    chk("abort busy", 32'(Busy), 32'd0);
    chk("abort sum kept", 32'(Adder_dataout), 32'hE1E1E1);
    @(negedge CLK);
    chk("abort one cycle", 32'(Abort), 32'd0);
    chk("abort ack later", 32'(Adder_ack), 32'd0);
    run_req("post-abort", 24'hFFFFFF, 24'h000001, 24'h000000, 1'b1, 2'b00);

    // Async reset mid-ADD.
    run_req("pre-rst", 24'h000ABC, 24'h000111, 24'h000BCD, 1'b0, 2'b00);
    @(negedge CLK);
    Adder_valid   = 1'b1;
    Adder_datain1 = 24'h400000;
    Adder_datain2 = 24'h400000;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rst add sum", 32'(Adder_dataout), 32'd0);
    chk("rst add busy", 32'(Busy), 32'd0);
    chk("rst add ack", 32'(Adder_ack), 32'd0);
    Adder_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    // Async reset mid-DONE.
    @(negedge CLK);
    Adder_valid   = 1'b1;
    Adder_datain1 = 24'h400000;
    Adder_datain2 = 24'hC00001;
    repeat (6) @(posedge CLK);   // capture + 4 ADD edges + one DONE hold edge
    @(negedge CLK);
    chk("done ack", 32'(Adder_ack), 32'd1);
    chk("done carry", 32'(Adder_carryout), 32'd1);
    #2 RST = 1'b1;
    #1;
    chk("rst done ack", 32'(Adder_ack), 32'd0);
    chk("rst done sum", 32'(Adder_dataout), 32'd0);
    chk("rst done carry", 32'(Adder_carryout), 32'd0);
    chk("rst done busy", 32'(Busy), 32'd0);
    Adder_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b0;

    run_req("post-rst", 24'h7FFFFF, 24'h000001, 24'h800000, 1'b0, 2'b00);

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mant_seg_adder.md
Name: mant_seg_adder

Overview:
- Multi-cycle segmented mantissa adder. It is the callee behind the FP add controller's Adder_* interface.
- The controller sends two 24-bit aligned mantissas (operand 2 already two's-complemented for effective subtraction) on a four-phase valid/ack handshake.
- The block returns the 24-bit sum, the carry-out and a 2-bit exception code.
- The carry chain is split into SEG_W-bit segments, one segment per clock, to keep the add off the critical path.

Parameters:
- DATA_W, 24, operand/sum width.
- SEG_W, 6, bits added per cycle. Must divide DATA_W exactly; an elaboration-time check fails otherwise.

Ports:
- CLK  input  1  clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- Adder_valid  input  1  request. Held high by the caller until Adder_ack is seen.
- Adder_datain1  input  DATA_W  operand A. Sampled only at request capture.
- Adder_datain2  input  DATA_W  operand B. Sampled only at request capture.
- Adder_ack  output  1  result valid. Held high until Adder_valid falls.
- Adder_dataout  output  DATA_W  sum[DATA_W-1:0].
- Adder_carryout  output  1  carry out of MSB.
- Adder_Exc  output  2  exception code. 00 none, 01 zero result; bit1 reserved, always 0.
- Busy  output  1  high in any state other than IDLE.
- Abort  output  1  one-cycle pulse when a request is withdrawn mid-add.

Behaviour:
- Reset (async, any state): state=IDLE; Adder_ack=0, Adder_dataout=0, Adder_carryout=0, Adder_Exc=00, Busy=0, Abort=0; operand regs, segment counter and carry reg cleared.
- All outputs are registered. No combinational path from inputs to outputs.
- NSEG = DATA_W/SEG_W; segment counter width is clog2(NSEG), minimum 1.
- IDLE:
  - On an edge with Adder_valid=1: latch A and B, set seg=0, carry=0, go to ADD.
  - Otherwise stay in IDLE.
- ADD, each edge:
  - {c, s} = A[seg] + B[seg] + carry, all SEG_W wide.
  - Write s into sum[seg*SEG_W +: SEG_W] and set carry=c.
  - If seg==NSEG-1, go to DONE. Otherwise increment seg.
- DONE entry, registered on the same edge as the last segment:
  - Adder_dataout = sum.
  - Adder_carryout = final carry.
  - Adder_Exc = 01 iff {carry, sum}==0, else 00.
  - Adder_ack = 1.
- DONE hold: stay while Adder_valid=1 with all outputs stable.
- DONE release: on the first edge with Adder_valid=0, drop Adder_ack to 0 and go to IDLE. Adder_dataout, Adder_carryout and Adder_Exc keep their last values until the next completion.
- Latency: Adder_ack is first high after NSEG edges counted from the capture edge (4 edges at the defaults).
- Throughput: one result per NSEG+2 cycles minimum.
- Withdrawal: if Adder_valid=0 on any ADD edge, discard the partial result, go to IDLE and pulse Abort for 1 cycle. Adder_ack stays 0 and the result outputs are not updated.
- Back-to-back requests: Adder_valid re-asserted on the same edge DONE returns to IDLE is not captured. Capture happens from IDLE only, so at least one cycle with Adder_ack=0 is always visible.
- Operand changes during ADD/DONE are ignored.
- Overflow is not the adder's concern; the carry-out is reported raw.

Optional Feature:
- ADDER_ZERO_DETECT_EN
- Defined: Adder_Exc[0] is the zero-result flag described above.
- Undefined: the zero-detect logic is removed and Adder_Exc is constant 00. The caller then detects zero itself during normalisation.

Test Plan:
- Basic add: A=24'h400000, B=24'h400000 -> after 4 edges ack=1, dataout=24'h800000, carry=0, Exc=00. Outputs held while valid stays high; ack=0 one edge after valid drops.
- Cross-segment carry: A=24'h000FFF, B=24'h000001 -> dataout=24'h001000, carry=0. This checks carry propagation across segments 1 and 2.
- Cancellation with carry: A=24'h123456, B=24'hEDCBAA (two's complement of A) -> dataout=0, carry=1, Exc=00.
- Zero result: A=0, B=0 -> dataout=0, carry=0, Exc=01 with ADDER_ZERO_DETECT_EN defined; Exc=00 without it.
- Abort: valid held high for 2 ADD cycles, then dropped -> Abort pulses once and ack never rises. A following request A=24'hFFFFFF, B=24'h000001 then returns dataout=0, carry=1.
- Async reset asserted mid-ADD and mid-DONE -> all outputs 0 immediately, without waiting for a clock edge. The next request completes normally with 4-edge latency.
